serial_adder: RTL and testbench
===============================

// Module: serial_adder
//
// PURPOSE
//   Parametrised digit-serial adder; successor to the single-bit full-adder cell.
//   Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
//   Adds DIGIT bits per clock, LSB first, through a registered carry.
//   Returns sum and carry-out over a second valid/ready handshake.
//   Used where area matters more than latency (wide counters, checksum units).
//
// PARAMETERS
//   WIDTH  8  operand and sum width in bits; must be >= 1.
//   DIGIT  1  bits added per cycle; must divide WIDTH (elaboration error otherwise).
//
// PORTS
//   clk        in   1      rising-edge clock.
//   rst_n      in   1      asynchronous, active-low reset.
//   in_valid   in   1      operands a/b/cin are valid.
//   in_ready   out  1      block can accept operands (high only in IDLE).
//   a          in   WIDTH  operand A.
//   b          in   WIDTH  operand B.
//   cin        in   1      carry-in.
//   out_valid  out  1      sum/cout are valid (high only in DONE).
//   out_ready  in   1      consumer accepts the result.
//   sum        out  WIDTH  a + b + cin, modulo 2^WIDTH.
//   cout       out  1      carry out of bit WIDTH-1.
//   busy       out  1      high in RUN or DONE.
//   ovf        out  1      signed overflow; present only with SERADD_OVF_EN.
//
// BEHAVIOUR
//   - States: IDLE, RUN, DONE. N = WIDTH/DIGIT digit steps.
//   - Reset (rst_n=0, async):
//     - State goes to IDLE. sum=0, cout=0, ovf=0, out_valid=0, busy=0.
//     - in_ready=1 (decoded from IDLE).
//     - Internal shift registers, carry and digit counter are cleared.
//   - IDLE -> RUN on a clock edge where in_valid && in_ready:
//     - Latch a and b into shift registers; carry <= cin; cnt <= 0.
//     - Outside this accept edge, a/b/cin are ignored.
//   - RUN, each edge:
//     - Add the lowest DIGIT bits of the A and B registers plus carry.
//     - Shift the DIGIT-bit result into sum from the MSB side.
//     - Shift the A and B registers right by DIGIT; carry <= digit carry-out; cnt++.
//     - On the edge where cnt == N-1: cout <= final carry; go to DONE.
//   - Latency: out_valid rises on the N-th edge after the accept edge.
//     - Example: WIDTH=8, DIGIT=1 gives 8 cycles; DIGIT=4 gives 2 cycles.
//   - DONE:
//     - out_valid=1. sum, cout and ovf are held stable until out_ready=1.
//     - On the edge with out_ready=1: go to IDLE; out_valid drops.
//     - sum, cout and ovf keep their last values until the next result.
//   - Acceptance timing:
//     - No new operand is accepted in RUN or DONE, because in_ready=0.
//     - The earliest next accept is the edge after the DONE->IDLE edge.
//     - Sustained throughput is therefore one result per N+2 cycles.
//   - Handshake rules:
//     - in_valid while in_ready=0 has no effect; the source must hold the request.
//     - out_ready outside DONE is ignored.
//   - Reset asserted mid-RUN or mid-DONE aborts the operation.
//     - The partial result is discarded and out_valid never pulses.
//   - Carry-chain arithmetic:
//     - Width is WIDTH+1 overall. Within a digit: DIGIT+1 bits, no saturation.
//     - Wrap-around: 0xFF + 0x01 gives sum 0x00 with cout=1.
//
// CONFIGURATION
//   SERADD_OVF_EN defined:
//     - Output ovf is present. It is written on the RUN->DONE edge:
//       ovf = carry into MSB XOR carry out of MSB (two's-complement overflow).
//     - ovf is reset to 0 and held with sum.
//   SERADD_OVF_EN undefined:
//     - Port ovf and its logic are absent. All other behaviour is identical.
//
// TESTING
//   1. WIDTH=1, DIGIT=1; drive all 8 a/b/cin combos.
//      -> {cout,sum} matches the full-adder truth table; out_valid 1 edge after accept.
//   2. WIDTH=8, DIGIT=1; a=0xFF, b=0x01, cin=0.
//      -> sum=0x00, cout=1, out_valid on the 8th edge after accept.
//   3. WIDTH=8, DIGIT=4, SERADD_OVF_EN; a=0x7F, b=0x01, cin=0.
//      -> sum=0x80, cout=0, ovf=1, latency 2.
//      Then a=0x80, b=0xFF, cin=1 -> sum=0x80, cout=1, ovf=0.
//   4. Backpressure; WIDTH=8, a=0x3C, b=0x05, cin=1; hold out_ready=0 for 5 cycles.
//      -> out_valid stays 1, sum=0x42, in_ready=0.
//      Then raise out_ready -> IDLE next edge; in_ready=1.
//   5. in_valid held high throughout.
//      -> Exactly one accept per N+2 cycles; a/b changed mid-RUN do not affect sum.
//   6. Deassert rst_n on the 3rd RUN cycle.
//      -> All outputs 0 and in_ready=1 immediately.
//      -> No out_valid; the next operation then computes correctly.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per clock LSB-first through a registered carry.
// Define SERADD_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // RUN   | adding one digit per clock
  // DONE  | result valid, waiting for out_ready

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dig_add;
  logic [WIDTH-1:0] sum_shift;
  logic             accept;
  logic             last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last      = (state == RUN) && (cnt == LAST);

  assign dig_add = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry};

  // Each new digit enters at the MSB, so after N steps the LSB digit has reached bit 0.
  if (DIGIT == WIDTH) begin : g_one_digit
    assign sum_shift = dig_add[DIGIT-1:0];
  end else begin : g_multi_digit
    assign sum_shift = {dig_add[DIGIT-1:0], sum[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      carry <= dig_add[DIGIT];
      sum   <= sum_shift;
      cnt   <= cnt + CW'(1);
      if (last) cout <= dig_add[DIGIT];
    end
  end

`ifdef SERADD_OVF_EN
  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (last) ovf <= a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ dig_add[DIGIT-1] ^ dig_add[DIGIT];
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three instances (W1/D1, W8/D1, W8/D4) on one clock.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       in_valid [3];
  logic       out_ready[3];
  logic       cin_v    [3];
  logic [7:0] a_v      [3];
  logic [7:0] b_v      [3];
  logic [7:0] sum_v    [3];
  logic       in_ready_v [3];
  logic       out_valid_v[3];
  logic       cout_v     [3];
  logic       busy_v     [3];
  logic       sum0;
`ifdef SERADD_OVF_EN
  logic       ovf_v[3];
`endif

  assign sum_v[0] = {7'b0, sum0};

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0][0:0]), .b(b_v[0][0:0]), .cin(cin_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready[0]), .sum(sum0), .cout(cout_v[0]), .busy(busy_v[0])
`ifdef SERADD_OVF_EN
    , .ovf(ovf_v[0])
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready[1]), .sum(sum_v[1]), .cout(cout_v[1]), .busy(busy_v[1])
`ifdef SERADD_OVF_EN
    , .ovf(ovf_v[1])
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready[2]), .sum(sum_v[2]), .cout(cout_v[2]), .busy(busy_v[2])
`ifdef SERADD_OVF_EN
    , .ovf(ovf_v[2])
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input int d, input logic [7:0] av, input logic [7:0] bv, input logic c);
    @(negedge clk);
    check_val("in_ready_before_accept", 32'(in_ready_v[d]), 1);
    in_valid[d] = 1'b1;
    a_v[d] = av;
    b_v[d] = bv;
    cin_v[d] = c;
    @(negedge clk);
    in_valid[d] = 1'b0;
    a_v[d] = ~av;
    b_v[d] = ~bv;
    cin_v[d] = ~c;
    check_val("busy_after_accept", 32'(busy_v[d]), 1);
  endtask

  task automatic wait_done(input int d, input int lat);
    int n = 0;
    while (!out_valid_v[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("latency", 32'(n), 32'(lat));
  endtask

  task automatic finish_op(input int d, input logic [7:0] es, input logic ec, input int eovf);
    check_val("sum", 32'(sum_v[d]), 32'(es));
    check_val("cout", 32'(cout_v[d]), 32'(ec));
    check_val("in_ready_in_done", 32'(in_ready_v[d]), 0);
`ifdef SERADD_OVF_EN
    if (eovf >= 0) check_val("ovf", 32'(ovf_v[d]), 32'(eovf));
`endif
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check_val("out_valid_after_release", 32'(out_valid_v[d]), 0);
    check_val("in_ready_after_release", 32'(in_ready_v[d]), 1);
    check_val("sum_held_after_release", 32'(sum_v[d]), 32'(es));
  endtask

  task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv, input logic c,
                        input logic [7:0] es, input logic ec, input int lat, input int eovf);
    start_op(d, av, bv, c);
    wait_done(d, lat);
    finish_op(d, es, ec, eovf);
  endtask

  // Full-adder truth table indexed by {a,b,cin}: value is {cout,sum}.
  logic [1:0] fa_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  logic [7:0] exp5_sum [3] = '{8'h33, 8'hFF, 8'h10};
  logic       exp5_cout[3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepts, results, last_acc, valid_seen;
    logic [2:0] idx;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; cin_v[i] = 1'b0;
      a_v[i] = '0; b_v[i] = '0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      check_val("rst_in_ready", 32'(in_ready_v[i]), 1);
      check_val("rst_out_valid", 32'(out_valid_v[i]), 0);
      check_val("rst_busy", 32'(busy_v[i]), 0);
      check_val("rst_sum", 32'(sum_v[i]), 0);
      check_val("rst_cout", 32'(cout_v[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Single-bit instance: full-adder truth table, latency 1.
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      run_op(0, {7'b0, idx[2]}, {7'b0, idx[1]}, idx[0],
             {7'b0, fa_tab[i][0]}, fa_tab[i][1], 1, -1);
    end

    // Bit-serial wrap-around.
    run_op(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8, 0);

    // Nibble-serial with signed overflow, then no overflow with cin.
    run_op(2, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 2, 1);
    run_op(2, 8'h80, 8'hFF, 1'b1, 8'h80, 1'b1, 2, 0);

    // Backpressure: result held while out_ready stays low.
    start_op(1, 8'h3C, 8'h05, 1'b1);
    wait_done(1, 8);
    repeat (5) begin
      @(negedge clk);
      check_val("bp_out_valid", 32'(out_valid_v[1]), 1);
      check_val("bp_in_ready", 32'(in_ready_v[1]), 0);
      check_val("bp_sum", 32'(sum_v[1]), 32'h42);
    end
    finish_op(1, 8'h42, 1'b0, 0);

    // in_valid held high: one accept per N+2 = 4 cycles; mid-RUN operand changes ignored.
    accepts = 0; results = 0; last_acc = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        in_valid[2] = 1'b1; out_ready[2] = 1'b1; cin_v[2] = 1'b0;
        a_v[2] = 8'h11; b_v[2] = 8'h22;
      end
      if (k == 1) begin a_v[2] = 8'hAA; b_v[2] = 8'h55; end
      if (k == 5) begin a_v[2] = 8'hF0; b_v[2] = 8'h20; end
      if (in_ready_v[2]) begin
        if (last_acc >= 0) check_val("accept_interval", 32'(k - last_acc), 4);
        last_acc = k;
        accepts++;
      end
      if (out_valid_v[2] && results < 3) begin
        check_val("stream_sum", 32'(sum_v[2]), 32'(exp5_sum[results]));
        check_val("stream_cout", 32'(cout_v[2]), 32'(exp5_cout[results]));
        results++;
      end
    end
    in_valid[2] = 1'b0;
    check_val("stream_accepts", 32'(accepts), 3);
    check_val("stream_results", 32'(results), 3);
    @(negedge clk);
    out_ready[2] = 1'b0;

    // Reset on the 3rd RUN cycle aborts the operation.
    start_op(1, 8'h5A, 8'h33, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_in_ready", 32'(in_ready_v[1]), 1);
    check_val("abort_out_valid", 32'(out_valid_v[1]), 0);
    check_val("abort_busy", 32'(busy_v[1]), 0);
    check_val("abort_sum", 32'(sum_v[1]), 0);
    check_val("abort_cout", 32'(cout_v[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    valid_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid_v[1]) valid_seen++;
    end
    check_val("abort_no_out_valid", 32'(valid_seen), 0);
    run_op(1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
